// File: rtl/mem_port_arbiter.sv
// Two-master arbiter and sequencer for the single shared Memory port.
// Round-robin on ties; reads hold the address for RD_LAT cycles, then return data with a one-cycle rvalid.
module mem_port_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_wr,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_wr,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_last;
  logic        r_owner;
  logic        r_wr;
  logic        r_mem_wr;
  logic        r_a_gnt;
  logic        r_b_gnt;
  logic        r_a_rvalid;
  logic        r_b_rvalid;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_a_rdata;
  logic [31:0] r_b_rdata;
  logic [2:0]  r_cnt;

  logic        w_win;
  logic        w_sel_b;
  logic        w_capture;
  logic        w_load_cnt;

  always_comb begin
    w_state_next = r_state;
    w_win        = 1'b0;
    w_sel_b      = 1'b0;
    w_capture    = 1'b0;
    w_load_cnt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (a_req || b_req) begin
          w_win        = 1'b1;
          // On a tie the port that did not win last time goes first.
          w_sel_b      = (a_req && b_req) ? ~r_last : b_req;
          w_state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_wr) begin
          w_state_next = S_IDLE;
        end else if (RD_LAT == 1) begin
          w_capture    = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_load_cnt   = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd1) begin
          w_capture    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_wr        <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_a_gnt     <= 1'b0;
      r_b_gnt     <= 1'b0;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_a_rdata   <= 32'd0;
      r_b_rdata   <= 32'd0;
      r_cnt       <= 3'd0;
    end else begin
      r_state    <= w_state_next;
      r_a_gnt    <= w_win & ~w_sel_b;
      r_b_gnt    <= w_win & w_sel_b;
      r_mem_wr   <= w_win & (w_sel_b ? b_wr : a_wr);
      r_a_rvalid <= w_capture & ~r_owner;
      r_b_rvalid <= w_capture & r_owner;
      if (w_win) begin
        r_owner     <= w_sel_b;
        r_last      <= w_sel_b;
        r_wr        <= w_sel_b ? b_wr : a_wr;
        r_mem_addr  <= w_sel_b ? b_addr : a_addr;
        r_mem_wdata <= w_sel_b ? b_wdata : a_wdata;
      end
      if (w_capture && !r_owner) begin
        r_a_rdata <= mem_rdata;
      end
      if (w_capture && r_owner) begin
        r_b_rdata <= mem_rdata;
      end
      if (w_load_cnt) begin
        r_cnt <= CNT_INIT;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  assign a_gnt     = r_a_gnt;
  assign b_gnt     = r_b_gnt;
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wr    = r_mem_wr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != S_IDLE);
  assign owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3.
// Stimulus pushes expected grants, read returns and signal snapshots; the monitor pops and compares.
module tb_mem_port_arbiter;

  typedef struct {
    int          d;
    int          p;
    int          kind;   // 0 gnt, 1 rvalid, 2 snapshot
    int          cyc;
    int          sig;
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] v2;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req     [2][2];
  logic        wr      [2][2];
  logic [31:0] addr    [2][2];
  logic [31:0] wdata   [2][2];
  logic        gnt     [2][2];
  logic        rvalid  [2][2];
  logic [31:0] rdata   [2][2];
  logic [31:0] mem_addr  [2];
  logic        mem_wr    [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];
  logic        owner     [2];

  int   cyc;
  int   n_chk;
  int   n_err;
  logic done;
  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [63:0] r_flag;
    logic [31:0] r_store [64];

    mem_port_arbiter #(.RD_LAT(gi == 0 ? 1 : 3)) u_dut (
      .clock    (clk),
      .reset    (rst),
      .a_req    (req[gi][0]),
      .a_wr     (wr[gi][0]),
      .a_addr   (addr[gi][0]),
      .a_wdata  (wdata[gi][0]),
      .a_gnt    (gnt[gi][0]),
      .a_rvalid (rvalid[gi][0]),
      .a_rdata  (rdata[gi][0]),
      .b_req    (req[gi][1]),
      .b_wr     (wr[gi][1]),
      .b_addr   (addr[gi][1]),
      .b_wdata  (wdata[gi][1]),
      .b_gnt    (gnt[gi][1]),
      .b_rvalid (rvalid[gi][1]),
      .b_rdata  (rdata[gi][1]),
      .mem_addr (mem_addr[gi]),
      .mem_wr   (mem_wr[gi]),
      .mem_wdata(mem_wdata[gi]),
      .mem_rdata(mem_rdata[gi]),
      .busy     (busy[gi]),
      .owner    (owner[gi])
    );

    // Unwritten words read as 0xC0DE0000 + word index.
    assign mem_rdata[gi] = r_flag[mem_addr[gi][7:2]] ? r_store[mem_addr[gi][7:2]]
                                                     : (32'hC0DE0000 | {26'd0, mem_addr[gi][7:2]});

    always @(posedge clk) begin
      if (rst) begin
        r_flag <= '0;
      end else if (mem_wr[gi]) begin
        r_flag[mem_addr[gi][7:2]]  <= 1'b1;
        r_store[mem_addr[gi][7:2]] <= mem_wdata[gi];
      end
    end
  end

  function automatic logic [31:0] sample(int d, int sig, int p);
    case (sig)
      0:       return {31'd0, busy[d]};
      1:       return {31'd0, mem_wr[d]};
      2:       return mem_addr[d];
      3:       return mem_wdata[d];
      4:       return {31'd0, owner[d]};
      5:       return rdata[d][p];
      6:       return {31'd0, gnt[d][p]};
      default: return {31'd0, rvalid[d][p]};
    endcase
  endfunction

  task automatic push_gnt(int d, int p, int c, logic [31:0] a, logic w, logic [31:0] wd);
    exp_t e;
    e = '{d: d, p: p, kind: 0, cyc: c, sig: 0, v0: a, v1: {31'd0, w}, v2: wd};
    q.push_back(e);
  endtask

  task automatic push_rv(int d, int p, int c, logic [31:0] rd);
    exp_t e;
    e = '{d: d, p: p, kind: 1, cyc: c, sig: 0, v0: rd, v1: 32'd0, v2: 32'd0};
    q.push_back(e);
  endtask

  task automatic push_snap(int d, int sig, int p, int c, logic [31:0] v);
    exp_t e;
    e = '{d: d, p: p, kind: 2, cyc: c, sig: sig, v0: v, v1: 32'd0, v2: 32'd0};
    q.push_back(e);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic match(int d, int p, int kind);
    int   idx;
    exp_t e;
    string tag;
    idx = -1;
    for (int k = 0; k < q.size(); k++) begin
      if (idx < 0 && q[k].d == d && q[k].p == p && q[k].kind == kind) idx = k;
    end
    tag = $sformatf("d%0d %s %s", d, p ? "B" : "A", kind ? "rvalid" : "gnt");
    if (idx < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s unexpected: got pulse at cycle %0d required none", tag, cyc);
      return;
    end
    e = q[idx];
    q.delete(idx);
    chk({tag, " cycle"}, cyc, e.cyc);
    if (kind == 0) begin
      chk({tag, " owner"}, {31'd0, owner[d]}, p);
      chk({tag, " busy"}, {31'd0, busy[d]}, 32'd1);
      chk({tag, " mem_addr"}, mem_addr[d], e.v0);
      chk({tag, " mem_wr"}, {31'd0, mem_wr[d]}, e.v1);
      chk({tag, " mem_wdata"}, mem_wdata[d], e.v2);
    end else begin
      chk({tag, " rdata"}, rdata[d][p], e.v0);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      while (q.size() > 0) begin
        n_chk++;
        n_err++;
        $display("FAIL d%0d port%0d kind%0d missing: got nothing required event at cycle %0d",
                 q[0].d, q[0].p, q[0].kind, q[0].cyc);
        void'(q.pop_front());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
    end else begin
      for (int i = 0; i < q.size(); ) begin
        if (q[i].kind == 2 && q[i].cyc == cyc) begin
          chk($sformatf("d%0d snap sig%0d p%0d cyc%0d", q[i].d, q[i].sig, q[i].p, cyc),
              sample(q[i].d, q[i].sig, q[i].p), q[i].v0);
          q.delete(i);
        end else begin
          i++;
        end
      end
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          if (gnt[d][p])    match(d, p, 0);
          if (rvalid[d][p]) match(d, p, 1);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(int d, int p, logic r, logic w, logic [31:0] a, logic [31:0] wd);
    req[d][p]   = r;
    wr[d][p]    = w;
    addr[d][p]  = a;
    wdata[d][p] = wd;
  endtask

  initial begin
    int t0;
    n_chk = 0;
    n_err = 0;
    done  = 1'b0;
    rst   = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) set_req(d, p, 1'b0, 1'b0, 32'd0, 32'd0);
    end

    // Reset state of both instances.
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 5; s++) push_snap(d, s, 0, 2, 32'd0);
      push_snap(d, 5, 0, 2, 32'd0);
      push_snap(d, 5, 1, 2, 32'd0);
    end
    step(3);
    rst = 1'b0;
    step(1);

    // RD_LAT=1: both ports reading continuously, A wins the first tie.
    t0 = cyc;
    set_req(0, 0, 1'b1, 1'b0, 32'h20, 32'd0);
    set_req(0, 1, 1'b1, 1'b0, 32'h24, 32'd0);
    push_gnt(0, 0, t0 + 1, 32'h20, 1'b0, 32'd0);
    push_rv (0, 0, t0 + 2, 32'hC0DE0008);
    push_gnt(0, 1, t0 + 3, 32'h24, 1'b0, 32'd0);
    push_rv (0, 1, t0 + 4, 32'hC0DE0009);
    push_gnt(0, 0, t0 + 5, 32'h20, 1'b0, 32'd0);
    push_rv (0, 0, t0 + 6, 32'hC0DE0008);
    push_gnt(0, 1, t0 + 7, 32'h24, 1'b0, 32'd0);
    push_rv (0, 1, t0 + 8, 32'hC0DE0009);
    step(7);
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    step(4);

    // RD_LAT=1: single A write, busy drops the cycle after the grant, address holds.
    t0 = cyc;
    set_req(0, 0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    push_gnt (0, 0, t0 + 1, 32'h10, 1'b1, 32'hDEADBEEF);
    push_snap(0, 0, 0, t0 + 2, 32'd0);
    push_snap(0, 1, 0, t0 + 2, 32'd0);
    push_snap(0, 2, 0, t0 + 2, 32'h10);
    step(1);
    req[0][0] = 1'b0;
    step(3);

    // RD_LAT=1: A reads back the written word; B's rdata is untouched.
    t0 = cyc;
    set_req(0, 0, 1'b1, 1'b0, 32'h10, 32'd0);
    push_gnt (0, 0, t0 + 1, 32'h10, 1'b0, 32'd0);
    push_rv  (0, 0, t0 + 2, 32'hDEADBEEF);
    push_snap(0, 5, 1, t0 + 3, 32'hC0DE0009);
    step(1);
    req[0][0] = 1'b0;
    step(3);

    // RD_LAT=3: B reads 0xFC; A arrives mid-read and waits for the rvalid cycle.
    t0 = cyc;
    set_req(1, 1, 1'b1, 1'b0, 32'hFC, 32'd0);
    push_gnt (1, 1, t0 + 1, 32'hFC, 1'b0, 32'd0);
    push_snap(1, 2, 0, t0 + 2, 32'hFC);
    push_snap(1, 2, 0, t0 + 3, 32'hFC);
    push_snap(1, 1, 0, t0 + 2, 32'd0);
    push_snap(1, 1, 0, t0 + 3, 32'd0);
    push_snap(1, 0, 0, t0 + 3, 32'd1);
    push_rv  (1, 1, t0 + 4, 32'hC0DE003F);
    step(1);
    req[1][1] = 1'b0;
    step(1);
    set_req(1, 0, 1'b1, 1'b0, 32'h08, 32'd0);
    push_gnt(1, 0, t0 + 5, 32'h08, 1'b0, 32'd0);
    push_rv (1, 0, t0 + 8, 32'hC0DE0002);
    step(3);
    req[1][0] = 1'b0;
    step(5);

    // RD_LAT=3: reset during WAIT clears everything before the next edge; no rvalid follows.
    t0 = cyc;
    set_req(1, 0, 1'b1, 1'b0, 32'h04, 32'd0);
    push_gnt(1, 0, t0 + 1, 32'h04, 1'b0, 32'd0);
    step(1);
    req[1][0] = 1'b0;
    step(1);
    #2;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 5; s++) push_snap(d, s, 0, t0 + 2, 32'd0);
      push_snap(d, 5, 0, t0 + 2, 32'd0);
      push_snap(d, 5, 1, t0 + 2, 32'd0);
    end
    step(1);
    rst = 1'b0;
    push_snap(1, 7, 0, t0 + 4, 32'd0);
    push_snap(1, 0, 0, t0 + 4, 32'd0);
    step(5);

    // RD_LAT=3: first tie after reset goes to A, then B.
    t0 = cyc;
    set_req(1, 0, 1'b1, 1'b0, 32'h00, 32'd0);
    set_req(1, 1, 1'b1, 1'b0, 32'h0C, 32'd0);
    push_gnt(1, 0, t0 + 1, 32'h00, 1'b0, 32'd0);
    push_rv (1, 0, t0 + 4, 32'hC0DE0000);
    push_gnt(1, 1, t0 + 5, 32'h0C, 1'b0, 32'd0);
    push_rv (1, 1, t0 + 8, 32'hC0DE0003);
    step(1);
    req[1][0] = 1'b0;
    step(4);
    req[1][1] = 1'b0;
    step(5);

    // RD_LAT=1: write then read from A with req held; second grant two cycles later.
    t0 = cyc;
    set_req(0, 0, 1'b1, 1'b1, 32'h30, 32'h12345678);
    push_gnt(0, 0, t0 + 1, 32'h30, 1'b1, 32'h12345678);
    step(1);
    wr[0][0] = 1'b0;
    push_gnt (0, 0, t0 + 3, 32'h30, 1'b0, 32'h12345678);
    push_snap(0, 1, 0, t0 + 3, 32'd0);
    push_rv  (0, 0, t0 + 4, 32'h12345678);
    step(2);
    req[0][0] = 1'b0;
    step(4);

    done = 1'b1;
    #100;
    $display("FAIL monitor: got no summary required summary within 100ns");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single shared `Memory` port of the multicycle MIPS core. It lets two requesters share the one address/data port: the CPU control path (port A) and a secondary master such as a loader or DMA (port B). It registers the winning request, drives the memory address, write strobe and write data for the required number of cycles, and returns read data with a one-cycle valid pulse. It sits between the `IorD` address mux output and `Memory`.

## Interface
Parameters:
- `RD_LAT`, default 1: cycles `Memory` needs with the address held stable before read data is captured. Legal range is 1..4.

Ports:
- `clock`, input, 1: single clock. All state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `a_req`, input, 1: port A request. Must be held until `a_gnt`.
- `a_wr`, input, 1: port A access type, 1 = write, 0 = read.
- `a_addr`, input, 32: port A byte address.
- `a_wdata`, input, 32: port A write data.
- `a_gnt`, output, 1: one-cycle pulse meaning port A's request was accepted.
- `a_rvalid`, output, 1: one-cycle pulse meaning `a_rdata` holds fresh read data.
- `a_rdata`, output, 32: last read data returned to port A.
- `b_req`, `b_wr`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: identical set for port B.
- `mem_addr`, output, 32: to `Memory.Address`.
- `mem_wr`, output, 1: to `Memory.Wr`.
- `mem_wdata`, output, 32: to `Memory.Datain`.
- `mem_rdata`, input, 32: from `Memory.Dataout`.
- `busy`, output, 1: high whenever the FSM is not in IDLE.
- `owner`, output, 1: requester being served, 0 = A, 1 = B. Only meaningful while `busy` is high.

## Operation
FSM states are IDLE, ACCESS and WAIT.

IDLE:
- If neither request is high, stay in IDLE.
- If exactly one request is high, that port wins.
- If both are high, round-robin picks the port that was not served last. A register `last` records the last winner.
- On the winning edge: latch the winner's addr, wr and wdata into the `mem_*` registers, latch the winner into `owner`, update `last`, and go to ACCESS.

ACCESS (always lasts exactly one cycle):
- The `gnt` of the owner is high.
- `mem_wr` equals the latched wr.
- Write: go to IDLE.
- Read with RD_LAT=1: capture `mem_rdata` into the owner's rdata register, then go to IDLE.
- Read with RD_LAT>1: load the counter with RD_LAT-1 and go to WAIT.

WAIT (reads only):
- `mem_addr` is held and `mem_wr` is 0.
- The counter decrements each cycle.
- When the counter equals 1: capture `mem_rdata` into the owner's rdata register and go to IDLE.

Read return:
- The owner's `rvalid` is high for the single cycle after the capture edge. That cycle is IDLE, so a new arbitration can happen in the same cycle.

Rules and boundary conditions:
- `mem_wr` is asserted for exactly one cycle per write and never during IDLE or WAIT.
- `mem_addr` and `mem_wdata` hold their last values in IDLE.
- The non-owner's request is ignored until IDLE. Its `gnt`, `rvalid` and `rdata` do not change.
- A request still high in the cycle where it is granted is not a new request. A request still high in a later IDLE cycle is treated as a new request, so requesters drop or change `req` after `gnt`.
- `rdata` keeps its value until that port's next read completes.
- Round-robin guarantees that a continuously requesting port waits at most one other transaction.
- Reset at any time:
  - State goes to IDLE.
  - All outputs go to 0, including `mem_wr`, `mem_addr`, `mem_wdata`, both `rdata`, `owner` and `busy`.
  - `last` is set to B, so A wins the first tie.
  - An in-flight read is discarded and produces no `rvalid`.

## Timing
- Request sampled high in IDLE at edge E0. `gnt`, `busy` and the `mem_*` outputs are valid in the cycle after E0 (ACCESS). There is no combinational path from `req` to any output.
- Write: IDLE → ACCESS → IDLE. Occupies 2 cycles; peak rate is 1 write every 2 cycles.
- Read: `rvalid` is high in the cycle E0+RD_LAT+1 counted from E0. The next arbitration happens in that same cycle.
- `mem_addr` is stable for RD_LAT consecutive cycles during a read.

## Test plan
1. Reset, then `a_req=1`, `a_wr=1`, `a_addr=0x10`, `a_wdata=0xDEADBEEF` at edge 0 → `a_gnt`, `mem_wr=1`, `mem_addr=0x10`, `mem_wdata=0xDEADBEEF` for one cycle. `busy` is low again in the cycle after.
2. RD_LAT=1: A reads 0x10 while the memory model returns 0xDEADBEEF → `a_rvalid` pulses 2 cycles after the request edge with `a_rdata=0xDEADBEEF`. `b_rdata` stays 0.
3. `a_req` and `b_req` both held high continuously, all reads → grants alternate A, B, A, B with A first after reset. `owner` matches each grant.
4. RD_LAT=3: B reads 0xFC → `mem_addr=0xFC` for 3 cycles and `b_rvalid` 4 cycles after the request edge. A request raised mid-read is granted only in the `b_rvalid` cycle.
5. `reset` asserted in the WAIT cycle of a RD_LAT=3 read → all outputs 0 asynchronously and no `rvalid` afterwards. The next tie is won by A.
6. A write followed immediately by a read from A with `req` never dropped → the second request is granted 2 cycles after the first. `mem_wr` is 0 during the read.
